fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch through a single-outstanding request/response instruction-memory port.
- Arbitrates the redirect sources (jump, branch, trap) and holds a redirect that arrives while a fetch is in flight.
- Presents one fetched instruction at a time to decode, with a stall-based hold.
- Sits between the redirect logic in execute/trap handling and instruction memory.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
jump  in  1  jump redirect request
jump_target  in  32  jump destination
branch_taken  in  1  taken-branch redirect request
branch_target  in  32  branch destination (pc+imm computed upstream)
trapped  in  1  trap redirect request
trap_target  in  32  trap vector
pipeline_stall  in  1  decode cannot accept; hold current instruction
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address
imem_ready  in  1  imem accepts request this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  response instruction word
instr  out  32  instruction to decode
instr_pc  out  32  PC of instr
instr_valid  out  1  instr is valid
pc  out  32  current PC register

Behaviour:
- State machine: IDLE, REQ, WAIT, HOLD.
- Registers: pc, instr, instr_pc, instr_valid, pend_valid, pend_target.
- Reset values: state=IDLE, pc=RESET_VECTOR, instr=0, instr_pc=0, instr_valid=0, pend_valid=0, pend_target=0.
- Reset mid-operation: any outstanding request is abandoned and the pending redirect is cleared.
- imem_req = (state==REQ), combinational. imem_addr = pc. Both are 0/pc at reset.
- Redirect selection, same cycle: jump > branch_taken > trapped.
  - redir = jump|branch_taken|trapped.
  - redir_target = the highest-priority asserted target.
- Effective redirect: eff = redir ? redir_target : pend_target, valid when redir|pend_valid.
- A live redirect overrides and replaces any pending one. The newest redirect wins.
- IDLE: imem_req=0. Always go to REQ next cycle. If redir: pend_valid<=1, pend_target<=redir_target.
- REQ:
  - imem_req=1. imem_addr and pc are held stable until imem_ready, even if a redirect arrives.
  - A redirect here is latched into pend.
  - On imem_ready, go to WAIT.
- WAIT:
  - Waits for imem_rvalid. A redirect without rvalid is latched into pend.
  - On imem_rvalid with an effective redirect: discard rdata, pc<=eff, pend_valid<=0, go to REQ. instr_valid stays 0.
  - On imem_rvalid otherwise: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP, go to HOLD.
- HOLD:
  - If effective redirect: flush with instr_valid<=0, pc<=eff, pend_valid<=0, go to REQ. Redirect takes priority over stall.
  - Else if !pipeline_stall: instruction consumed this cycle. instr_valid<=0, go to REQ.
  - Else remain in HOLD; instr, instr_pc and instr_valid are unchanged.
- Latency: with imem_ready=1 and 1-cycle rvalid, the first instr_valid is asserted 3 cycles after reset deasserts. Steady-state throughput is one instruction per 3 cycles (REQ, WAIT, HOLD).
- imem_rvalid outside WAIT is ignored, e.g. a stale response after reset.
- Arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No carry out.
- Redirect targets are used unmodified. There is no alignment check; misalignment is handled by the trap logic.
- pc always reflects the address of the next fetch to be issued or in flight.

Test Plan:
1. Reset with RESET_VECTOR=0x100, imem_ready=1, rvalid one cycle after accept, stall=0 -> imem_addr sequence 0x100, 0x104, 0x108. instr_pc matches. instr_valid is one pulse per 3 cycles.
2. jump=1 to 0x200 together with trapped=1 to 0x80 during WAIT, same cycle as rvalid -> rdata discarded, next imem_addr=0x200, no instr_valid for that fetch.
3. branch_taken to 0x40 in REQ while imem_ready=0 for 3 cycles -> imem_addr stays at old pc until accept. Response discarded, then imem_addr=0x40.
4. pipeline_stall=1 for 5 cycles in HOLD with instr=0x00500093 -> instr and instr_valid held stable, imem_req=0. Stall drops -> next request at instr_pc+4.
5. trapped to 0x1C0 while in HOLD with stall=1 -> instr_valid=0 next cycle, imem_addr=0x1C0.
6. pc=0xFFFF_FFFC fetch completes -> pc=0x0000_0000. Assert reset during WAIT, then rvalid arrives in IDLE -> ignored, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory port of the fetch sequencer: single-outstanding
// request/accept handshake plus a response strobe carrying the fetched word.
interface fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, issues one fetch at a time and
// arbitrates jump/branch/trap redirects, parking any that arrive mid-fetch.
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] PC_STEP      = 32'd4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     jump,
   input  logic [31:0]              jump_target,
   input  logic                     branch_taken,
   input  logic [31:0]              branch_target,
   input  logic                     trapped,
   input  logic [31:0]              trap_target,
   input  logic                     pipeline_stall,
   fetch_sequencer_if.master        imem,
   output logic [31:0]              instr,
   output logic [31:0]              instr_pc,
   output logic                     instr_valid,
   output logic [31:0]              pc
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] pc_r;
   logic [31:0] pc_nxt_s;
   logic [31:0] instr_r;
   logic [31:0] instr_nxt_s;
   logic [31:0] instr_pc_r;
   logic [31:0] instr_pc_nxt_s;
   logic        instr_valid_r;
   logic        instr_valid_nxt_s;
   logic        pend_valid_r;
   logic        pend_valid_nxt_s;
   logic [31:0] pend_target_r;
   logic [31:0] pend_target_nxt_s;

   logic        redir_s;
   logic [31:0] redir_target_s;
   logic        eff_valid_s;
   logic [31:0] eff_target_s;

   // Fixed-priority redirect select: jump beats branch beats trap.
   always_comb begin
      redir_s        = jump | branch_taken | trapped;
      redir_target_s = 32'h0000_0000;
      if (jump) begin
         redir_target_s = jump_target;
      end else if (branch_taken) begin
         redir_target_s = branch_target;
      end else if (trapped) begin
         redir_target_s = trap_target;
      end else begin
         redir_target_s = 32'h0000_0000;
      end
   end

   // A live redirect supersedes whatever was parked earlier.
   assign eff_valid_s  = redir_s | pend_valid_r;
   assign eff_target_s = redir_s ? redir_target_s : pend_target_r;

   // Next-state and datapath update for the fetch FSM.
   always_comb begin
      state_nxt_s       = state_r;
      pc_nxt_s          = pc_r;
      instr_nxt_s       = instr_r;
      instr_pc_nxt_s    = instr_pc_r;
      instr_valid_nxt_s = instr_valid_r;
      pend_valid_nxt_s  = pend_valid_r;
      pend_target_nxt_s = pend_target_r;

      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_REQ;
            if (redir_s) begin
               pend_valid_nxt_s  = 1'b1;
               pend_target_nxt_s = redir_target_s;
            end else begin
               pend_valid_nxt_s  = pend_valid_r;
            end
         end

         ST_REQ: begin
            // The address must not move under an unaccepted request.
            if (redir_s) begin
               pend_valid_nxt_s  = 1'b1;
               pend_target_nxt_s = redir_target_s;
            end else begin
               pend_valid_nxt_s  = pend_valid_r;
            end
            if (imem.imem_ready) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end

         ST_WAIT: begin
            if (imem.imem_rvalid) begin
               if (eff_valid_s) begin
                  pc_nxt_s         = eff_target_s;
                  pend_valid_nxt_s = 1'b0;
                  state_nxt_s      = ST_REQ;
               end else begin
                  instr_nxt_s       = imem.imem_rdata;
                  instr_pc_nxt_s    = pc_r;
                  instr_valid_nxt_s = 1'b1;
                  pc_nxt_s          = pc_r + PC_STEP;
                  state_nxt_s       = ST_HOLD;
               end
            end else if (redir_s) begin
               pend_valid_nxt_s  = 1'b1;
               pend_target_nxt_s = redir_target_s;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end

         ST_HOLD: begin
            if (eff_valid_s) begin
               instr_valid_nxt_s = 1'b0;
               pc_nxt_s          = eff_target_s;
               pend_valid_nxt_s  = 1'b0;
               state_nxt_s       = ST_REQ;
            end else if (!pipeline_stall) begin
               instr_valid_nxt_s = 1'b0;
               state_nxt_s       = ST_REQ;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end

         default: begin
            state_nxt_s       = ST_IDLE;
            instr_valid_nxt_s = 1'b0;
            pend_valid_nxt_s  = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // PC, decode-facing instruction and parked-redirect registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r          <= RESET_VECTOR;
         instr_r       <= 32'h0000_0000;
         instr_pc_r    <= 32'h0000_0000;
         instr_valid_r <= 1'b0;
         pend_valid_r  <= 1'b0;
         pend_target_r <= 32'h0000_0000;
      end else begin
         pc_r          <= pc_nxt_s;
         instr_r       <= instr_nxt_s;
         instr_pc_r    <= instr_pc_nxt_s;
         instr_valid_r <= instr_valid_nxt_s;
         pend_valid_r  <= pend_valid_nxt_s;
         pend_target_r <= pend_target_nxt_s;
      end
   end

   assign imem.imem_req  = (state_r == ST_REQ);
   assign imem.imem_addr = pc_r;
   assign instr          = instr_r;
   assign instr_pc       = instr_pc_r;
   assign instr_valid    = instr_valid_r;
   assign pc             = pc_r;

   fetch_sequencer_checker u_checker (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem.imem_req),
      .imem_ready     (imem.imem_ready),
      .imem_addr      (pc_r),
      .in_hold        (state_r == ST_HOLD),
      .instr_valid    (instr_valid_r),
      .instr          (instr_r),
      .pipeline_stall (pipeline_stall),
      .eff_valid      (eff_valid_s)
   );

endmodule

// Protocol invariants of the fetch sequencer.
module fetch_sequencer_checker (
   input logic        clk,
   input logic        reset,
   input logic        imem_req,
   input logic        imem_ready,
   input logic [31:0] imem_addr,
   input logic        in_hold,
   input logic        instr_valid,
   input logic [31:0] instr,
   input logic        pipeline_stall,
   input logic        eff_valid
);

   a_addr_stable: assert property (@(posedge clk) disable iff (reset)
      (imem_req && !imem_ready) |=> (imem_req && (imem_addr == $past(imem_addr))));

   a_valid_in_hold: assert property (@(posedge clk) disable iff (reset)
      instr_valid == in_hold);

   a_stall_hold: assert property (@(posedge clk) disable iff (reset)
      (instr_valid && pipeline_stall && !eff_valid) |=> (instr_valid && $stable(instr)));

endmodule
